// File: rtl/jpeg_enc_pkg.sv
// Shared constants, packer state encoding and mask helper for the JPEG entropy output stage.
package jpeg_enc_pkg;

    localparam logic [7:0] MARKER_FF  = 8'hFF;
    localparam logic [7:0] STUFF_BYTE = 8'h00;
    localparam logic       PAD_BIT    = 1'b1;

    // Widest mask len_mask can produce; callers truncate to their own width.
    localparam int unsigned MASK_W = 64;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } packer_state_t;

    // Low 'len' bits set.
    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        if (len >= MASK_W) begin
            return '1;
        end
        return (MASK_W'(1) << len) - MASK_W'(1);
    endfunction

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Output byte register with JPEG 0xFF/0x00 stuffing and out_last alignment.
module jpeg_byte_stuffer
    import jpeg_enc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       load_last,
    output logic       can_load,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic       out_last
);

    logic stuff_pending;
    logic stuff_last;
    logic slot_free;

    assign slot_free = !out_valid || out_ready;
    // A pending 0x00 must go out before any further data byte.
    assign can_load  = slot_free && !stuff_pending;

    // Output register: stuffing byte has priority, then a fresh data byte.
    // When the final data byte is 0xFF, out_last moves onto the trailing 0x00.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_byte      <= '0;
            out_last      <= 1'b0;
            stuff_pending <= 1'b0;
            stuff_last    <= 1'b0;
        end else if (slot_free) begin
            if (stuff_pending) begin
                out_valid     <= 1'b1;
                out_byte      <= STUFF_BYTE;
                out_last      <= stuff_last;
                stuff_pending <= 1'b0;
                stuff_last    <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
                out_byte  <= load_byte;
                if (load_byte == MARKER_FF) begin
                    out_last      <= 1'b0;
                    stuff_pending <= 1'b1;
                    stuff_last    <= load_last;
                end else begin
                    out_last <= load_last;
                end
            end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jpeg_huffman_bit_packer.sv
// MSB-first bit packer for Huffman codes: accumulator, fill counter and flush FSM.
module jpeg_huffman_bit_packer
    import jpeg_enc_pkg::*;
#(
    parameter int unsigned CODE_W = 16,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned LEN_W  = $clog2(CODE_W + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CODE_W-1:0]            in_code,
    input  logic [LEN_W-1:0]             in_len,
    input  logic                         in_flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_byte,
    output logic                         out_last,
    output logic                         flush_done,
    output logic [$clog2(ACC_W+1)-1:0]   fill_level,
    output logic                         len_err
);

    localparam int unsigned FILL_W = $clog2(ACC_W + 1);

    if (ACC_W < CODE_W + 8) begin : g_acc_too_small
        $error("jpeg_huffman_bit_packer: ACC_W must be >= CODE_W+8");
    end

    packer_state_t state, state_next;

    logic [ACC_W-1:0]  acc, acc_next;
    logic [FILL_W-1:0] fill, fill_next;

    logic              accept;
    logic              len_over;
    logic [LEN_W-1:0]  len_eff;
    logic [CODE_W-1:0] code_masked;
    logic              can_load;
    logic              extract;
    logic              extract_last;
    logic [ACC_W-1:0]  acc_aligned;
    logic [7:0]        extract_byte;
    logic [3:0]        pad_n;
    logic [7:0]        pad_bits;

    assign accept      = in_valid && in_ready;
    assign len_over    = 32'(in_len) > CODE_W;
    assign len_eff     = len_over ? LEN_W'(CODE_W) : in_len;
    assign code_masked = in_code & CODE_W'(len_mask(32'(len_eff)));

    // Top eight valid bits sit at [fill-1 : fill-8]; bits above fill are stale.
    assign extract      = can_load && (fill >= FILL_W'(8)) && (state == RUN || state == DRAIN);
    assign extract_last = (state == DRAIN) && (fill == FILL_W'(8));
    assign acc_aligned  = acc >> (fill - FILL_W'(8));
    assign extract_byte = acc_aligned[7:0];

    assign pad_n    = (fill[2:0] == 3'd0) ? 4'd0 : 4'(4'd8 - {1'b0, fill[2:0]});
    assign pad_bits = 8'(len_mask(32'(pad_n))) & {8{PAD_BIT}};

    assign fill_level = fill;

    // State, accumulator and sticky length-error registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            acc     <= '0;
            fill    <= '0;
            len_err <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            fill  <= fill_next;
            if (accept && len_over) begin
                len_err <= 1'b1;
            end
        end
    end

    // Next state, accumulator update and handshake outputs.
    // Accept and extraction may coincide in RUN; both adjust fill in the same cycle.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        fill_next  = fill;
        in_ready   = 1'b0;
        flush_done = 1'b0;
        case (state)
            RUN: begin
                in_ready = fill <= FILL_W'(ACC_W - CODE_W);
                if (accept) begin
                    acc_next = (acc << len_eff) | ACC_W'(code_masked);
                    if (in_flush) begin
                        state_next = PAD;
                    end
                end
                fill_next = fill + (accept ? FILL_W'(len_eff) : '0)
                                 - (extract ? FILL_W'(8) : '0);
            end
            PAD: begin
                acc_next   = (acc << pad_n) | ACC_W'(pad_bits);
                fill_next  = fill + FILL_W'(pad_n);
                state_next = DRAIN;
            end
            DRAIN: begin
                fill_next = fill - (extract ? FILL_W'(8) : '0);
                if (fill == '0 && can_load) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                flush_done = 1'b1;
                fill_next  = '0;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    jpeg_byte_stuffer u_stuffer (
        .clock     (clock),
        .reset     (reset),
        .load      (extract),
        .load_byte (extract_byte),
        .load_last (extract_last),
        .can_load  (can_load),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_byte  (out_byte),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_jpeg_huffman_bit_packer.sv
// Directed self-checking bench for jpeg_huffman_bit_packer (CODE_W=16, ACC_W=32).
module tb_jpeg_huffman_bit_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_code;
    logic [4:0]  in_len;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        flush_done;
    logic [5:0]  fill_level;
    logic        len_err;

    int tests = 0;
    int fails = 0;

    logic [7:0] got_byte[$];
    logic       got_last[$];
    int         flush_pulses = 0;

    jpeg_huffman_bit_packer #(.CODE_W(16), .ACC_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_len     (in_len),
        .in_flush   (in_flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_last   (out_last),
        .flush_done (flush_done),
        .fill_level (fill_level),
        .len_err    (len_err)
    );

    always #5 clock = ~clock;

    // Record every transferred byte and every flush_done pulse.
    always @(posedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                got_byte.push_back(out_byte);
                got_last.push_back(out_last);
            end
            if (flush_done) begin
                flush_pulses++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [15:0] c, input logic [4:0] l, input logic f);
        int n;
        n = 0;
        in_code  = c;
        in_len   = l;
        in_flush = f;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick(1);
            n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        tick(1);
        in_valid = 1'b0;
        in_flush = 1'b0;
        in_code  = '0;
        in_len   = '0;
    endtask

    initial begin
        int base;
        int pulses;
        logic [7:0] exp5 [8];

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        in_len    = '0;
        in_flush  = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_byte", 32'(out_byte), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);

        // 1: 101 + 11110 -> 0xBE
        base = got_byte.size();
        send(16'h0005, 5'd3, 1'b0);
        send(16'h001E, 5'd5, 1'b0);
        tick(3);
        check("t1_count", 32'(got_byte.size()), 32'(base + 1));
        check("t1_byte", 32'(got_byte[base]), 32'hBE);
        check("t1_last", 32'(got_last[base]), 32'd0);
        check("t1_fill", 32'(fill_level), 32'd0);

        // 2: 0xFF then 0x12 -> FF 00 12
        base = got_byte.size();
        send(16'h00FF, 5'd8, 1'b0);
        send(16'h0012, 5'd8, 1'b0);
        tick(6);
        check("t2_count", 32'(got_byte.size()), 32'(base + 3));
        check("t2_b0", 32'(got_byte[base]), 32'hFF);
        check("t2_b1", 32'(got_byte[base+1]), 32'h00);
        check("t2_b2", 32'(got_byte[base+2]), 32'h12);

        // 3: 010 with flush -> 0x5F last, flush_done next cycle
        base   = got_byte.size();
        pulses = flush_pulses;
        send(16'h0002, 5'd3, 1'b1);
        check("t3_pad_in_ready", 32'(in_ready), 32'd0);
        check("t3_pad_flush_done", 32'(flush_done), 32'd0);
        tick(1);
        check("t3_drain_in_ready", 32'(in_ready), 32'd0);
        check("t3_drain_out_valid", 32'(out_valid), 32'd0);
        tick(1);
        check("t3_out_valid", 32'(out_valid), 32'd1);
        check("t3_out_byte", 32'(out_byte), 32'h5F);
        check("t3_out_last", 32'(out_last), 32'd1);
        check("t3_early_done", 32'(flush_done), 32'd0);
        tick(1);
        check("t3_flush_done", 32'(flush_done), 32'd1);
        check("t3_done_in_ready", 32'(in_ready), 32'd0);
        check("t3_done_out_valid", 32'(out_valid), 32'd0);
        tick(1);
        check("t3_after_done", 32'(flush_done), 32'd0);
        check("t3_run_in_ready", 32'(in_ready), 32'd1);
        check("t3_fill", 32'(fill_level), 32'd0);
        check("t3_pulses", 32'(flush_pulses), 32'(pulses + 1));
        check("t3_count", 32'(got_byte.size()), 32'(base + 1));

        // 4: 1111111 + 1 with flush -> FF, 00(last)
        base   = got_byte.size();
        pulses = flush_pulses;
        send(16'h007F, 5'd7, 1'b0);
        send(16'h0001, 5'd1, 1'b1);
        tick(8);
        check("t4_count", 32'(got_byte.size()), 32'(base + 2));
        check("t4_b0", 32'(got_byte[base]), 32'hFF);
        check("t4_b0_last", 32'(got_last[base]), 32'd0);
        check("t4_b1", 32'(got_byte[base+1]), 32'h00);
        check("t4_b1_last", 32'(got_last[base+1]), 32'd1);
        check("t4_pulses", 32'(flush_pulses), 32'(pulses + 1));
        check("t4_in_ready", 32'(in_ready), 32'd1);

        // 5: back-pressure with 16-bit beats
        base = got_byte.size();
        exp5 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        out_ready = 1'b0;
        send(16'h1234, 5'd16, 1'b0);
        send(16'h5678, 5'd16, 1'b0);
        check("t5_fill_full", 32'(fill_level), 32'd24);
        check("t5_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 20; i++) begin
            check("t5_hold", {22'd0, in_ready, out_valid, out_byte}, {22'd0, 1'b0, 1'b1, 8'h12});
            tick(1);
        end
        out_ready = 1'b1;
        send(16'h9ABC, 5'd16, 1'b0);
        send(16'hDEF0, 5'd16, 1'b0);
        tick(8);
        check("t5_count", 32'(got_byte.size()), 32'(base + 8));
        for (int i = 0; i < 8; i++) begin
            check("t5_stream", 32'(got_byte[base+i]), 32'(exp5[i]));
        end
        check("t5_fill_end", 32'(fill_level), 32'd0);

        // 6: over-length beat, sticky len_err, async reset mid-DRAIN
        base   = got_byte.size();
        pulses = flush_pulses;
        out_ready = 1'b0;
        check("t6_len_err_pre", 32'(len_err), 32'd0);
        send(16'hABCD, 5'd31, 1'b0);
        check("t6_len_err", 32'(len_err), 32'd1);
        check("t6_fill16", 32'(fill_level), 32'd16);
        send(16'h0003, 5'd2, 1'b0);
        check("t6_len_err_sticky", 32'(len_err), 32'd1);
        check("t6_fill10", 32'(fill_level), 32'd10);
        send(16'h0000, 5'd0, 1'b1);
        tick(3);
        check("t6_drain_in_ready", 32'(in_ready), 32'd0);
        check("t6_drain_out_valid", 32'(out_valid), 32'd1);
        check("t6_drain_out_byte", 32'(out_byte), 32'hAB);
        check("t6_drain_fill", 32'(fill_level), 32'd16);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_fill", 32'(fill_level), 32'd0);
        check("t6_rst_in_ready", 32'(in_ready), 32'd1);
        check("t6_rst_len_err", 32'(len_err), 32'd0);
        check("t6_rst_out_byte", 32'(out_byte), 32'd0);
        check("t6_rst_out_last", 32'(out_last), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        check("t6_no_bytes", 32'(got_byte.size()), 32'(base));
        check("t6_no_pulse", 32'(flush_pulses), 32'(pulses));

        // 7: empty flush -> no bytes, flush_done two cycles after accept
        out_ready = 1'b1;
        base   = got_byte.size();
        send(16'h0000, 5'd0, 1'b1);
        check("t7_done_c0", 32'(flush_done), 32'd0);
        tick(1);
        check("t7_done_c1", 32'(flush_done), 32'd0);
        tick(1);
        check("t7_done_c2", 32'(flush_done), 32'd1);
        tick(1);
        check("t7_done_c3", 32'(flush_done), 32'd0);
        check("t7_in_ready", 32'(in_ready), 32'd1);
        check("t7_no_bytes", 32'(got_byte.size()), 32'(base));
        check("t7_len_err", 32'(len_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
